// File: rtl/fetch_aligner_pkg.sv
// Shared types and constants for the fetch aligner: FSM state encoding and
// the RISC-V instruction-length mask.
package fetch_aligner_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      FULLW,
      HI,
      SPLIT
   } fetch_align_state_e;

   localparam logic [1:0] ILEN_MASK_C = 2'b11;

   function automatic logic is_compressed(input logic [15:0] hw);
      return hw[1:0] != ILEN_MASK_C;
   endfunction

endpackage

// File: rtl/fetch_aligner_out_reg.sv
// One-entry valid/ready output stage for the fetch aligner; full throughput,
// cleared by reset and by a redirect.
module fetch_out_reg (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_instr_i,
   input  logic [31:0] in_pc_i,
   input  logic        in_comp_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_pc_o,
   output logic        out_comp_o
);

   logic        valid_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic        comp_q;

   assign in_ready_o  = !valid_q || out_ready_i;
   assign out_valid_o = valid_q && !flush_i;
   assign out_instr_o = instr_q;
   assign out_pc_o    = pc_q;
   assign out_comp_o  = comp_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
         comp_q  <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (in_valid_i && in_ready_o) begin
         valid_q <= 1'b1;
         instr_q <= in_instr_i;
         pc_q    <= in_pc_i;
         comp_q  <= in_comp_i;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_aligner.sv
// Splits a 32-bit fetch word stream into 16/32-bit instructions with PCs.
// Define FETCH_ALIGNER_OUT_REG_EN to add a registered output stage.
module fetch_aligner
   import fetch_aligner_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic [31:0] fetch_addr_o,
   input  logic        fetch_valid_i,
   input  logic [31:0] fetch_rdata_i,
   output logic        fetch_ready_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        is_compressed_o
);

   fetch_align_state_e state_q;
   logic [31:0]        word_q;
   logic [15:0]        hw_q;
   logic [31:0]        pc_q;
   logic               skip_q;
   logic [31:0]        fetch_addr_q;

   logic        core_valid;
   logic        core_ready;
   logic [31:0] core_instr;
   logic        core_comp;
   logic        fetch_ready_c;
   logic        hi_comp;
   logic        fetch_xfer;
   logic        instr_hs;
   logic        unused_flush_pc_bit0;

   assign unused_flush_pc_bit0 = flush_pc_i[0];
   assign hi_comp = is_compressed(word_q[31:16]);

   always_comb begin
      core_valid    = 1'b0;
      core_instr    = '0;
      fetch_ready_c = 1'b0;
      unique case (state_q)
         EMPTY: fetch_ready_c = 1'b1;
         FULLW: begin
            core_valid = 1'b1;
            core_instr = is_compressed(word_q[15:0]) ? {16'h0000, word_q[15:0]} : word_q;
         end
         HI: begin
            if (hi_comp) begin
               core_valid = 1'b1;
               core_instr = {16'h0000, word_q[31:16]};
            end else begin
               fetch_ready_c = 1'b1;
            end
         end
         SPLIT: begin
            core_valid = 1'b1;
            core_instr = {word_q[15:0], hw_q};
         end
         default: ;
      endcase
      if (flush_i) begin
         core_valid    = 1'b0;
         fetch_ready_c = 1'b0;
      end
   end

   assign core_comp     = core_instr[1:0] != ILEN_MASK_C;
   assign fetch_ready_o = fetch_ready_c;
   assign fetch_addr_o  = fetch_addr_q;
   assign fetch_xfer    = fetch_valid_i && fetch_ready_c;
   assign instr_hs      = core_valid && core_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= EMPTY;
         word_q       <= '0;
         hw_q         <= '0;
         pc_q         <= {BOOT_ADDR[31:1], 1'b0};
         skip_q       <= BOOT_ADDR[1];
         fetch_addr_q <= {BOOT_ADDR[31:2], 2'b00};
      end else if (flush_i) begin
         state_q      <= EMPTY;
         word_q       <= '0;
         hw_q         <= '0;
         pc_q         <= {flush_pc_i[31:1], 1'b0};
         skip_q       <= flush_pc_i[1];
         fetch_addr_q <= {flush_pc_i[31:2], 2'b00};
      end else begin
         if (fetch_xfer) begin
            fetch_addr_q <= fetch_addr_q + 32'd4;
         end
         if (instr_hs) begin
            pc_q <= pc_q + (core_comp ? 32'd2 : 32'd4);
         end
         unique case (state_q)
            EMPTY: begin
               if (fetch_xfer) begin
                  word_q  <= fetch_rdata_i;
                  state_q <= skip_q ? HI : FULLW;
                  skip_q  <= 1'b0;
               end
            end
            FULLW: begin
               if (instr_hs) begin
                  state_q <= core_comp ? HI : EMPTY;
               end
            end
            HI: begin
               // An uncompressed upper half is parked in hw_q while the
               // following word supplies its upper 16 bits.
               if (hi_comp) begin
                  if (instr_hs) begin
                     state_q <= EMPTY;
                  end
               end else if (fetch_xfer) begin
                  hw_q    <= word_q[31:16];
                  word_q  <= fetch_rdata_i;
                  state_q <= SPLIT;
               end
            end
            SPLIT: begin
               if (instr_hs) begin
                  state_q <= HI;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

`ifdef FETCH_ALIGNER_OUT_REG_EN
   fetch_out_reg u_out_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (core_valid),
      .in_ready_o  (core_ready),
      .in_instr_i  (core_instr),
      .in_pc_i     (pc_q),
      .in_comp_i   (core_comp),
      .out_valid_o (instr_valid_o),
      .out_ready_i (instr_ready_i),
      .out_instr_o (instr_o),
      .out_pc_o    (instr_pc_o),
      .out_comp_o  (is_compressed_o)
   );
`else
   assign core_ready      = instr_ready_i;
   assign instr_valid_o   = core_valid;
   assign instr_o         = core_instr;
   assign instr_pc_o      = pc_q;
   assign is_compressed_o = core_comp;
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed scenarios plus a randomized
// run against a memory-image reference model.
module tb_fetch_aligner;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] flush_pc_i = '0;
   logic [31:0] fetch_addr_o;
   logic        fetch_valid_i = 1'b0;
   logic [31:0] fetch_rdata_i = '0;
   logic        fetch_ready_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        is_compressed_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];
   logic [64:0] got_q [$];

   always #5 clk_i = ~clk_i;

   fetch_aligner #(.BOOT_ADDR(32'h0000_0000)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .flush_pc_i      (flush_pc_i),
      .fetch_addr_o    (fetch_addr_o),
      .fetch_valid_i   (fetch_valid_i),
      .fetch_rdata_i   (fetch_rdata_i),
      .fetch_ready_o   (fetch_ready_o),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .is_compressed_o (is_compressed_o)
   );

   // Halfword of the memory image at byte address a (bit 0 ignored).
   function automatic logic [15:0] mem_hw(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input bit fv, input bit rdy);
      fetch_valid_i = fv;
      instr_ready_i = rdy;
      fetch_rdata_i = mem[fetch_addr_o[9:2]];
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      flush_i = 1'b0;
      fetch_valid_i = 1'b0;
      instr_ready_i = 1'b0;
      next_cycle();
      rst_i = 1'b0;
   endtask

   task automatic collect(input int n, input int budget);
      got_q.delete();
      for (int c = 0; c < budget && got_q.size() < n; c++) begin
         drive(1'b1, 1'b1);
         @(negedge clk_i);
         if (instr_valid_o && instr_ready_i)
            got_q.push_back({instr_o, instr_pc_o, is_compressed_o});
         next_cycle();
      end
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b0, 1'b0);
      @(negedge clk_i);
      checks++;
      if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || fetch_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_state got valid=%b ready=%b addr=%h want valid=0 ready=1 addr=00000000",
                  instr_valid_o, fetch_ready_o, fetch_addr_o);
      end
      next_cycle();
   endtask

   task automatic test_word32();
      mem[0] = 32'h0000_0013;
      do_reset();
      drive(1'b1, 1'b1);
      @(negedge clk_i);
      checks++;
      if (fetch_ready_o !== 1'b1 || instr_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL word32_xfer got ready=%b valid=%b want ready=1 valid=0", fetch_ready_o, instr_valid_o);
      end
      next_cycle();
      drive(1'b0, 1'b1);
      @(negedge clk_i);
      checks++;
      if ({instr_valid_o, instr_o, instr_pc_o, is_compressed_o, fetch_addr_o} !==
          {1'b1, 32'h0000_0013, 32'h0, 1'b0, 32'h4}) begin
         errors++;
         $display("FAIL word32_out got v=%b i=%h pc=%h c=%b fa=%h want v=1 i=00000013 pc=00000000 c=0 fa=00000004",
                  instr_valid_o, instr_o, instr_pc_o, is_compressed_o, fetch_addr_o);
      end
      next_cycle();
   endtask

   task automatic test_compressed_pair();
      logic [64:0] exp [2];
      exp = '{{32'h0000_4501, 32'h0, 1'b1}, {32'h0000_4501, 32'h2, 1'b1}};
      mem[0] = 32'h4501_4501;
      do_reset();
      collect(2, 20);
      checks++;
      if (got_q.size() != 2) begin
         errors++;
         $display("FAIL cpair_count got %0d want 2", got_q.size());
      end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL cpair_%0d got %h want %h", i, got_q[i], exp[i]);
         end
      end
   endtask

   task automatic test_split();
      logic [64:0] exp [3];
      exp = '{{32'h0000_4501, 32'h0, 1'b1}, {32'h0000_0013, 32'h2, 1'b0}, {32'h0000_4501, 32'h6, 1'b1}};
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h4501_0000;
      do_reset();
      collect(3, 30);
      checks++;
      if (got_q.size() != 3) begin
         errors++;
         $display("FAIL split_count got %0d want 3", got_q.size());
      end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL split_%0d got %h want %h", i, got_q[i], exp[i]);
         end
      end
   endtask

   task automatic test_flush();
      logic [64:0] exp [2];
      exp = '{{32'h0000_4501, 32'h102, 1'b1}, {32'h0000_0013, 32'h104, 1'b0}};
      mem[8'h40] = 32'h4501_0000;
      mem[8'h41] = 32'h0000_0013;
      do_reset();
      flush_i = 1'b1;
      flush_pc_i = 32'h0000_0102;
      drive(1'b1, 1'b1);
      @(negedge clk_i);
      checks++;
      if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_gate got valid=%b ready=%b want 0 0", instr_valid_o, fetch_ready_o);
      end
      next_cycle();
      flush_i = 1'b0;
      drive(1'b0, 1'b1);
      @(negedge clk_i);
      checks++;
      if (fetch_addr_o !== 32'h0000_0100) begin
         errors++;
         $display("FAIL flush_addr got %h want 00000100", fetch_addr_o);
      end
      next_cycle();
      collect(2, 20);
      checks++;
      if (got_q.size() != 2) begin
         errors++;
         $display("FAIL flush_count got %0d want 2", got_q.size());
      end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL flush_%0d got %h want %h", i, got_q[i], exp[i]);
         end
      end
   endtask

   task automatic test_stall();
      mem[0] = 32'h0000_0013;
      do_reset();
      drive(1'b1, 1'b0);
      @(negedge clk_i);
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0);
         @(negedge clk_i);
         checks++;
         if ({instr_valid_o, instr_o, instr_pc_o, fetch_ready_o} !== {1'b1, 32'h0000_0013, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL stall_%0d got v=%b i=%h pc=%h rdy=%b want v=1 i=00000013 pc=00000000 rdy=0",
                     i, instr_valid_o, instr_o, instr_pc_o, fetch_ready_o);
         end
         next_cycle();
      end
      drive(1'b0, 1'b1);
      @(negedge clk_i);
      next_cycle();
      drive(1'b0, 1'b1);
      @(negedge clk_i);
      checks++;
      if (instr_valid_o !== 1'b0 || fetch_addr_o !== 32'h4) begin
         errors++;
         $display("FAIL stall_release got valid=%b fa=%h want 0 00000004", instr_valid_o, fetch_addr_o);
      end
      next_cycle();
   endtask

   // Walk EMPTY -> FULLW -> HI -> SPLIT; leaves the DUT in SPLIT.
   task automatic reach_split();
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h4501_0000;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1);
         @(negedge clk_i);
         next_cycle();
      end
   endtask

   task automatic test_split_abort();
      mem[8'h80] = 32'h4501_4501;
      reach_split();
      flush_i = 1'b1;
      flush_pc_i = 32'h0000_0200;
      drive(1'b1, 1'b1);
      @(negedge clk_i);
      checks++;
      if (instr_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL split_flush_valid got %b want 0", instr_valid_o);
      end
      next_cycle();
      flush_i = 1'b0;
      collect(1, 20);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {32'h0000_4501, 32'h200, 1'b1}) begin
         errors++;
         $display("FAIL split_flush_next got n=%0d %h want %h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 65'h0, {32'h0000_4501, 32'h200, 1'b1});
      end

      reach_split();
      rst_i = 1'b1;
      drive(1'b1, 1'b0);
      @(negedge clk_i);
      next_cycle();
      rst_i = 1'b0;
      drive(1'b0, 1'b0);
      @(negedge clk_i);
      checks++;
      if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || fetch_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL split_reset_state got valid=%b ready=%b addr=%h want 0 1 00000000",
                  instr_valid_o, fetch_ready_o, fetch_addr_o);
      end
      next_cycle();
      collect(1, 20);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== {32'h0000_4501, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL split_reset_next got n=%0d %h want %h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 65'h0, {32'h0000_4501, 32'h0, 1'b1});
      end
   endtask

   task automatic test_wrap();
      mem[8'hFF] = 32'h0000_0013;
      do_reset();
      flush_i = 1'b1;
      flush_pc_i = 32'hFFFF_FFFC;
      drive(1'b0, 1'b0);
      @(negedge clk_i);
      next_cycle();
      flush_i = 1'b0;
      drive(1'b1, 1'b1);
      @(negedge clk_i);
      next_cycle();
      drive(1'b0, 1'b1);
      @(negedge clk_i);
      checks++;
      if ({fetch_addr_o, instr_valid_o, instr_o, instr_pc_o} !== {32'h0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFC}) begin
         errors++;
         $display("FAIL wrap got fa=%h v=%b i=%h pc=%h want fa=00000000 v=1 i=00000013 pc=fffffffc",
                  fetch_addr_o, instr_valid_o, instr_o, instr_pc_o);
      end
      next_cycle();
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, exp_fa, fp, exp_instr;
      logic [15:0] h, lo;
      logic [64:0] held, obs, exp;
      bit          stalled;
      int          len;
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 2; k++) begin
            h = 16'($urandom);
            if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
            else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
            if (k == 0) mem[i][15:0] = h;
            else mem[i][31:16] = h;
         end
      end
      do_reset();
      exp_pc = 32'h0;
      exp_fa = 32'h0;
      stalled = 1'b0;
      held = '0;
      for (int c = 0; c < 4000; c++) begin
         flush_i = ($urandom_range(0, 49) == 0);
         fp = $urandom;
         flush_pc_i = fp;
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
         @(negedge clk_i);
         obs = {instr_o, instr_pc_o, is_compressed_o};
         checks++;
         if (fetch_addr_o !== exp_fa) begin
            errors++;
            $display("FAIL rand_faddr cycle %0d got %h want %h", c, fetch_addr_o, exp_fa);
         end
         if (flush_i) begin
            checks++;
            if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
               errors++;
               $display("FAIL rand_flush cycle %0d got valid=%b ready=%b want 0 0", c, instr_valid_o, fetch_ready_o);
            end
            exp_pc = {fp[31:1], 1'b0};
            exp_fa = {fp[31:2], 2'b00};
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               checks++;
               if (instr_valid_o !== 1'b1 || obs !== held) begin
                  errors++;
                  $display("FAIL rand_stable cycle %0d got v=%b %h want v=1 %h", c, instr_valid_o, obs, held);
               end
            end
            if (fetch_valid_i && fetch_ready_o) exp_fa = exp_fa + 32'd4;
            if (instr_valid_o && instr_ready_i) begin
               lo = mem_hw(exp_pc);
               if (lo[1:0] != 2'b11) begin
                  exp_instr = {16'h0000, lo};
                  len = 2;
               end else begin
                  exp_instr = {mem_hw(exp_pc + 32'd2), lo};
                  len = 4;
               end
               exp = {exp_instr, exp_pc, (len == 2)};
               checks++;
               if (obs !== exp) begin
                  errors++;
                  $display("FAIL rand_instr cycle %0d got %h want %h", c, obs, exp);
               end
               exp_pc = exp_pc + 32'(len);
            end
            stalled = instr_valid_o && !instr_ready_i;
            held = obs;
         end
         next_cycle();
      end
      flush_i = 1'b0;
   endtask

   initial begin
      @(posedge clk_i);
      #1;
      test_reset();
      test_word32();
      test_compressed_pair();
      test_split();
      test_flush();
      test_stall();
      test_split_abort();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, first PC after reset (bit 0 ignored).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush_i  input  1  redirect request, highest priority.
REQ-005 SHALL have port flush_pc_i  input  32  redirect target; bit 0 ignored, bit 1 significant.
REQ-006 SHALL have port fetch_addr_o  output  32  word-aligned address of next fetch word.
REQ-007 SHALL have port fetch_valid_i  input  1  memory word available for fetch_addr_o.
REQ-008 SHALL have port fetch_rdata_i  input  32  memory word.
REQ-009 SHALL have port fetch_ready_o  output  1  aligner accepts word; transfer = fetch_valid_i & fetch_ready_o.
REQ-010 SHALL have port instr_valid_o  output  1  instruction available to decode.
REQ-011 SHALL have port instr_ready_i  input  1  decode accepts; handshake = instr_valid_o & instr_ready_i.
REQ-012 SHALL have port instr_o  output  32  raw instruction; bits 31:16 zero when compressed.
REQ-013 SHALL have port instr_pc_o  output  32  halfword-aligned PC of instr_o.
REQ-014 SHALL have port is_compressed_o  output  1  instr_o[1:0] != 2'b11.

Function
REQ-015 SHALL implement states EMPTY, FULLW (whole word buffered, next instr at offset 0), HI (only upper halfword valid), SPLIT (32-bit instr straddling two words).
REQ-016 SHALL hold a 32-bit word register, a 16-bit residual register hw_q, PC register pc_q and skip flag skip_q.
REQ-017 fetch_ready_o SHALL be 1 only in EMPTY, or in HI with uncompressed residual, and 0 whenever flush_i=1.
REQ-018 On each fetch transfer fetch_addr_o SHALL advance by 4 (wrap modulo 2^32).
REQ-019 EMPTY + transfer SHALL go to FULLW, or HI if skip_q=1 (skip_q then clears).
REQ-020 FULLW SHALL present word[15:0] if compressed (handshake -> HI), else the full word (handshake -> EMPTY).
REQ-021 HI with compressed upper half SHALL present it (handshake -> EMPTY).
REQ-022 HI with uncompressed upper half SHALL copy it to hw_q, capture next word on transfer, go to SPLIT; instr_valid_o=0 meanwhile.
REQ-023 SPLIT SHALL present {word[15:0], hw_q} (handshake -> HI).
REQ-024 pc_q SHALL advance by 2 on compressed handshake, 4 on uncompressed handshake.
REQ-025 Outputs SHALL be stable while instr_valid_o=1 and instr_ready_i=0.
REQ-026 Latency SHALL be 1 cycle: word transferred in cycle N gives instr_valid_o in N+1.
REQ-027 flush_i SHALL force instr_valid_o=0 that cycle, discard all buffered data, set state EMPTY, fetch_addr_o={flush_pc_i[31:2],2'b00}, pc_q={flush_pc_i[31:1],1'b0}, skip_q=flush_pc_i[1].
REQ-028 flush_i coinciding with a fetch transfer or instr handshake SHALL ignore both.

Reset
REQ-029 rst_i SHALL take priority over flush_i.
REQ-030 Reset SHALL set state EMPTY, instr_valid_o=0, fetch_ready_o=1, fetch_addr_o={BOOT_ADDR[31:2],2'b00}, pc_q={BOOT_ADDR[31:1],0}, skip_q=BOOT_ADDR[1], registers zero.
REQ-031 Reset asserted mid-SPLIT SHALL drop the straddling instruction with no output.

Configuration
REQ-032 With FETCH_ALIGNER_OUT_REG_EN defined, a 1-entry valid/ready output register SHALL be inserted: latency 2 cycles, full throughput (ready = !valid | instr_ready_i), cleared by rst_i and flush_i.
REQ-033 Without FETCH_ALIGNER_OUT_REG_EN, outputs SHALL be driven directly from state per REQ-020..023.

Structure
REQ-034 Shared package pkg SHALL hold the state enum typedef fetch_align_state_e and constant ILEN_MASK_C = 2'b11.
REQ-035 The output register SHALL be sub-module fetch_out_reg, instantiated only under FETCH_ALIGNER_OUT_REG_EN.

Verification
REQ-036 Reset, BOOT_ADDR=0, word 32'h0000_0013 -> next cycle instr_o=32'h0000_0013, pc 0, is_compressed_o=0, fetch_addr_o=4.
REQ-037 Word 32'h4501_4501 -> instr_o=32'h0000_4501 at pc 0 then pc 2, both is_compressed_o=1.
REQ-038 Words 32'h0013_4501, 32'h4501_0000 -> 32'h0000_4501@0, 32'h0000_0013@2, 32'h0000_4501@6.
REQ-039 flush_i with flush_pc_i=32'h102 -> fetch_addr_o=32'h100; word 32'h4501_0000 -> single 32'h0000_4501@32'h102.
REQ-040 instr_ready_i=0 for 3 cycles in FULLW -> instr_o/instr_pc_o stable, fetch_ready_o=0.
REQ-041 flush_i in SPLIT, and rst_i in SPLIT -> no straddling instruction emitted; reset restores REQ-030 values.
